song_sequencer: RTL



---
 rtl/song_pkg.sv | 35 +++
 rtl/song_sequencer_if.sv | 13 +
 rtl/song_sequencer_tick_prescaler.sv | 23 ++
 rtl/song_sequencer.sv | 85 ++++++++
 4 files changed

// File: rtl/song_pkg.sv
// song_pkg: note codes, half-period table, song ROM and FSM state for the music-box sequencer
package song_pkg;

    typedef enum logic [3:0] {REST, C4, D4, E4, F4, G4, A4, AS4, B4, C5} note_e;

    typedef enum logic [1:0] {IDLE, LOAD, SOUND, GAP} state_t;

    localparam int SONG_LEN = 25;

    // Divisors are twice the rounded note frequency, so each entry folds to a constant.
    function automatic logic [15:0] half_period_of(logic [3:0] code, int unsigned clk_hz);
        case (code)
            C4:      return 16'(clk_hz / 524);
            D4:      return 16'(clk_hz / 588);
            E4:      return 16'(clk_hz / 660);
            F4:      return 16'(clk_hz / 698);
            G4:      return 16'(clk_hz / 784);
            A4:      return 16'(clk_hz / 880);
            AS4:     return 16'(clk_hz / 932);
            B4:      return 16'(clk_hz / 988);
            C5:      return 16'(clk_hz / 1046);
            default: return 16'd0;
        endcase
    endfunction

    // Entries are {code[3:0], dur_ms[9:0]}.
    localparam logic [13:0] SONG_ROM [SONG_LEN] = '{
        {C4, 10'd225}, {C4, 10'd75}, {D4, 10'd300}, {C4, 10'd300}, {F4, 10'd300},
        {E4, 10'd600}, {C4, 10'd225}, {C4, 10'd75}, {D4, 10'd300}, {C4, 10'd300},
        {G4, 10'd300}, {F4, 10'd600}, {C4, 10'd225}, {C4, 10'd75}, {C5, 10'd300},
        {A4, 10'd300}, {F4, 10'd300}, {E4, 10'd300}, {D4, 10'd600}, {AS4, 10'd225},
        {AS4, 10'd75}, {AS4, 10'd300}, {F4, 10'd300}, {G4, 10'd300}, {F4, 10'd600}
    };

endpackage

// File: rtl/song_sequencer_if.sv
// song_sequencer_if: play control in, tone-stage drive out
interface song_sequencer_if;
    logic        play;
    logic        restart;
    logic [15:0] half_period;
    logic        tone_en;
    logic [4:0]  note_idx;
    logic        note_strobe;
    logic        song_done;

    modport master (output play, restart, input half_period, tone_en, note_idx, note_strobe, song_done);
    modport slave  (input play, restart, output half_period, tone_en, note_idx, note_strobe, song_done);
endinterface

// File: rtl/song_sequencer_tick_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle duration tick, freezable and clearable
module tick_prescaler #(
    parameter int unsigned DIV = 12_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(DIV + 1);

    logic [W-1:0] cnt;

    assign tick = en && cnt == W'(DIV - 1);

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: walks the song ROM and drives the tone stage with divisor, enable and note timing
module song_sequencer
    import song_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 12_000_000,
    parameter int unsigned TICK_HZ   = 1000,
    parameter int unsigned GAP_TICKS = 20
) (
    input logic              clk,
    input logic              rst_n,
    song_sequencer_if.slave  bus
);
    state_t      state;
    logic [13:0] cur;
    logic [13:0] rom_word;
    logic [9:0]  tick_cnt;
    logic [9:0]  sound_ticks;
    logic        tick;
    logic        running;
    logic        sound_end;
    logic        gap_end;
    logic        last_note;

    assign rom_word    = SONG_ROM[bus.note_idx];
    assign sound_ticks = cur[9:0] > 10'(GAP_TICKS) ? cur[9:0] - 10'(GAP_TICKS) : 10'd1;
    assign running     = bus.play && (state == SOUND || state == GAP);
    assign sound_end   = tick && tick_cnt == sound_ticks - 10'd1;
    assign gap_end     = tick && tick_cnt == 10'(GAP_TICKS - 1);
    assign last_note   = bus.note_idx == 5'(SONG_LEN - 1);

    tick_prescaler #(.DIV(CLK_HZ / TICK_HZ)) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (running),
        .clr  (state == LOAD || bus.restart),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            cur             <= '0;
            tick_cnt        <= '0;
            bus.half_period <= '0;
            bus.tone_en     <= 1'b0;
            bus.note_idx    <= '0;
            bus.note_strobe <= 1'b0;
            bus.song_done   <= 1'b0;
        end else begin
            bus.note_strobe <= 1'b0;
            bus.song_done   <= 1'b0;
            if (bus.restart) begin
                state        <= bus.play ? LOAD : IDLE;
                tick_cnt     <= '0;
                bus.tone_en  <= 1'b0;
                bus.note_idx <= '0;
            end else begin
                case (state)
                    IDLE: state <= bus.play ? LOAD : IDLE;
                    LOAD: begin
                        cur             <= rom_word;
                        tick_cnt        <= '0;
                        bus.half_period <= half_period_of(rom_word[13:10], CLK_HZ);
                        bus.tone_en     <= bus.play && rom_word[13:10] != REST;
                        bus.note_strobe <= 1'b1;
                        state           <= SOUND;
                    end
                    SOUND: begin
                        tick_cnt    <= sound_end ? '0 : tick_cnt + 10'(tick);
                        bus.tone_en <= !sound_end && bus.play && cur[13:10] != REST;
                        state       <= sound_end ? GAP : SOUND;
                    end
                    GAP: begin
                        tick_cnt <= gap_end ? '0 : tick_cnt + 10'(tick);
                        state    <= gap_end ? LOAD : GAP;
                        if (gap_end) begin
                            bus.note_idx  <= last_note ? '0 : bus.note_idx + 5'd1;
                            bus.song_done <= last_note;
                        end
                    end
                endcase
            end
        end
    end
endmodule
